// File: rtl/bytewrite_ram_req_master_if.sv
// Command and response channels between a system-side requester and the
// byte-write RAM request master.
interface bytewrite_ram_req_master_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int COL_WIDTH  = 9,
  parameter int NB_COL     = 4,
  parameter int LEN_WIDTH  = 4
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [NB_COL-1:0]             cmd_we;
  logic [ADDR_WIDTH-1:0]         cmd_addr;
  logic [LEN_WIDTH-1:0]          cmd_len;
  logic [NB_COL*COL_WIDTH-1:0]   cmd_wdata;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [NB_COL*COL_WIDTH-1:0]   rsp_data;
  logic                          rsp_last;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/bytewrite_ram_req_master.sv
// Sequences fill/read bursts onto a read-first byte-write RAM port and returns
// read data through a 2-entry back-pressurable response FIFO.
module bytewrite_ram_req_master #(
  parameter int ADDR_WIDTH = 10,
  parameter int COL_WIDTH  = 9,
  parameter int NB_COL     = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  bytewrite_ram_req_master_if.slave   bus,
  output logic [NB_COL-1:0]           ram_we,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [NB_COL*COL_WIDTH-1:0] ram_di,
  input  logic [NB_COL*COL_WIDTH-1:0] ram_do
);
  localparam int DW = NB_COL * COL_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READ
  } state_t;

  state_t                state_q, state_d;
  logic [NB_COL-1:0]     we_q;
  logic [DW-1:0]         wdata_q;
  logic [ADDR_WIDTH-1:0] cur_q;
  logic [LEN_WIDTH-1:0]  cnt_q;

  logic                  load;
  logic                  issue;
  logic                  cmd_ready;

  logic                  inflight_q;
  logic                  inflight_last_q;

  logic [DW-1:0]         fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_cnt;
  logic                  push, pop;
  logic                  rsp_valid;
  logic [2:0]            occupancy;
  logic                  room;

  assign rsp_valid = (fifo_cnt != 2'd0);
  assign pop       = rsp_valid && bus.rsp_ready;
  assign push      = inflight_q;

  // Entries that will occupy the FIFO after this edge must stay below its depth.
  assign occupancy = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
  assign room      = (occupancy < 3'd2);

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    issue     = 1'b0;
    cmd_ready = 1'b0;
    ram_we    = '0;
    ram_di    = '0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = !rst;
        if (bus.cmd_valid && !rst) begin
          load    = 1'b1;
          state_d = (bus.cmd_we != '0) ? FILL : READ;
        end
      end
      FILL: begin
        if (!rst) begin
          issue  = 1'b1;
          ram_we = we_q;
          ram_di = wdata_q;
          if (cnt_q == '0) state_d = IDLE;
        end
      end
      READ: begin
        if (!rst && room) begin
          issue = 1'b1;
          if (cnt_q == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_addr      = cur_q;
  assign bus.cmd_ready = cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      we_q            <= '0;
      wdata_q         <= '0;
      cur_q           <= '0;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        we_q    <= bus.cmd_we;
        wdata_q <= bus.cmd_wdata;
        cur_q   <= bus.cmd_addr;
        cnt_q   <= bus.cmd_len;
      end else if (issue) begin
        cur_q <= cur_q + ADDR_WIDTH'(1);
        cnt_q <= cnt_q - LEN_WIDTH'(1);
      end
      inflight_q      <= issue && (state_q == READ);
      inflight_last_q <= (cnt_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= ram_do;
      fifo_last[wr_ptr] <= inflight_last_q;
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign bus.rsp_last  = rsp_valid ? fifo_last[rd_ptr] : 1'b0;
endmodule
